// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg : state encoding and default timing constants for the calculator
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_A  = 3'd1,
    GET_B  = 3'd2,
    GET_OP = 3'd3,
    EXEC   = 3'd4,
    SHOW   = 3'd5,
    ERROR  = 3'd6
  } calc_state_t;

  localparam int unsigned CALC_TIMEOUT_DEFAULT = 64;
  localparam int unsigned CALC_TW_DEFAULT      = 7;

endpackage

`default_nettype wire

// File: rtl/rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect : one-bit registered rising-edge detector, async reset
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

`default_nettype wire

// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer : button-driven control FSM for operand/operator capture and
//                  ALU execution with timeout
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = CALC_TIMEOUT_DEFAULT,
  parameter int unsigned TW             = CALC_TW_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic       alu_done,
  input  logic       alu_error,
  output logic       load_a,
  output logic       load_b,
  output logic       load_op,
  output logic       alu_start,
  output logic       result_valid,
  output logic       err,
  output logic       busy,
  output logic [2:0] state_code
);

  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  calc_state_t   state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;
  logic          enter_rise;
  logic          clear_rise;

  rise_detect u_enter_rise (
    .clk    (clk),
    .reset  (reset),
    .d_i    (btn_enter),
    .rise_o (enter_rise)
  );

  rise_detect u_clear_rise (
    .clk    (clk),
    .reset  (reset),
    .d_i    (btn_clear),
    .rise_o (clear_rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Clear pre-empts every state and masks any pulse decoded in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = 1'b0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_op   = 1'b0;
    alu_start = 1'b0;
    if (clear_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enter_rise) state_d = GET_A;
        end
        GET_A: begin
          if (enter_rise) begin
            state_d = GET_B;
            load_a  = 1'b1;
          end
        end
        GET_B: begin
          if (enter_rise) begin
            state_d = GET_OP;
            load_b  = 1'b1;
          end
        end
        GET_OP: begin
          if (enter_rise) begin
            state_d = EXEC;
            load_op = 1'b1;
            cnt_d   = '0;
            first_d = 1'b1;
          end
        end
        EXEC: begin
          alu_start = first_q;
          cnt_d     = cnt_q + 1'b1;
          if (alu_done) begin
            state_d = alu_error ? ERROR : SHOW;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = ERROR;
          end
        end
        SHOW, ERROR: begin
          if (enter_rise) state_d = GET_A;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign result_valid = (state_q == SHOW);
  assign err          = (state_q == ERROR);
  assign busy         = (state_q == EXEC);
  assign state_code   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_sequencer : scoreboard bench for calc_sequencer
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_calc_sequencer;

  localparam logic [3:0] C_P_A     = 4'b0001;
  localparam logic [3:0] C_P_B     = 4'b0010;
  localparam logic [3:0] C_P_OP    = 4'b0100;
  localparam logic [3:0] C_P_START = 4'b1000;
  localparam logic [3:0] C_P_NONE  = 4'b0000;

  typedef struct {
    logic [3:0] vec;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic       alu_done = 1'b0;
  logic       alu_error = 1'b0;
  logic       load_a, load_b, load_op, alu_start;
  logic       result_valid, err, busy;
  logic [2:0] state_code;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];

  calc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .btn_enter    (btn_enter),
    .btn_clear    (btn_clear),
    .alu_done     (alu_done),
    .alu_error    (alu_error),
    .load_a       (load_a),
    .load_b       (load_b),
    .load_op      (load_op),
    .alu_start    (alu_start),
    .result_valid (result_valid),
    .err          (err),
    .busy         (busy),
    .state_code   (state_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Every load/start pulse seen must match the next queued expectation.
  always @(negedge clk) begin
    logic [3:0] v;
    exp_t       e;
    v = {alu_start, load_op, load_b, load_a};
    if (v != C_P_NONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", int'(v), 0);
      end else begin
        e = sb.pop_front();
        chk("pulse_vec", int'(v), int'(e.vec));
        chk("pulse_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v, input int c);
    exp_t e;
    e.vec = v;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic press_enter(input logic [3:0] pv);
    @(posedge clk);
    #1;
    btn_enter = 1'b1;
    if (pv != C_P_NONE) push(pv, cyc);
    if (pv == C_P_OP) push(C_P_START, cyc + 1);
    @(posedge clk);
    #1;
    btn_enter = 1'b0;
  endtask

  task automatic press_clear();
    @(posedge clk);
    #1;
    btn_clear = 1'b1;
    @(posedge clk);
    #1;
    btn_clear = 1'b0;
  endtask

  task automatic pulse_done(input logic e);
    @(posedge clk);
    #1;
    alu_done  = 1'b1;
    alu_error = e;
    @(posedge clk);
    #1;
    alu_done  = 1'b0;
    alu_error = 1'b0;
  endtask

  task automatic to_exec();
    press_enter(C_P_A);
    press_enter(C_P_B);
    press_enter(C_P_OP);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int found;

    // Reset values
    tick(3);
    chk("rst_state", int'(state_code), 0);
    chk("rst_outs", int'({load_a, load_b, load_op, alu_start, result_valid, err, busy}), 0);
    @(negedge clk);
    reset = 1'b0;

    // Main sequence and successful ALU result
    tick(3);
    press_enter(C_P_NONE);
    chk("seq_get_a", int'(state_code), 1);
    press_enter(C_P_A);
    chk("seq_get_b", int'(state_code), 2);
    press_enter(C_P_B);
    chk("seq_get_op", int'(state_code), 3);
    press_enter(C_P_OP);
    chk("seq_exec", int'(state_code), 4);
    chk("seq_busy", int'(busy), 1);
    tick(2);
    pulse_done(1'b0);
    chk("show_state", int'(state_code), 5);
    chk("show_valid", int'(result_valid), 1);
    chk("show_busy", int'(busy), 0);
    press_enter(C_P_NONE);
    chk("show_to_get_a", int'(state_code), 1);
    chk("show_valid_drop", int'(result_valid), 0);

    // ALU error, with an ignored enter during EXEC
    to_exec();
    press_enter(C_P_NONE);
    chk("exec_enter_ignored", int'(state_code), 4);
    pulse_done(1'b1);
    chk("alu_err_state", int'(state_code), 6);
    chk("alu_err_flag", int'(err), 1);
    chk("alu_err_valid", int'(result_valid), 0);
    press_enter(C_P_NONE);
    chk("err_to_get_a", int'(state_code), 1);

    // Timeout: ERROR exactly 64 cycles after alu_start
    to_exec();
    s = cyc;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (state_code == 3'd6) begin
        found = 1;
        break;
      end
    end
    chk("timeout_reached", found, 1);
    chk("timeout_latency", cyc - s, 64);
    chk("timeout_err", int'(err), 1);
    press_enter(C_P_NONE);
    chk("timeout_to_get_a", int'(state_code), 1);

    // Held enter gives one event only
    @(posedge clk);
    #1;
    btn_enter = 1'b1;
    push(C_P_A, cyc);
    tick(20);
    chk("held_enter_state", int'(state_code), 2);
    btn_enter = 1'b0;
    tick(1);

    // Simultaneous clear and enter in GET_B: clear wins, no load_b
    @(posedge clk);
    #1;
    btn_enter = 1'b1;
    btn_clear = 1'b1;
    tick(1);
    chk("clr_enter_state", int'(state_code), 0);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(1);

    // Clear during EXEC, then a late done is ignored
    press_enter(C_P_NONE);
    to_exec();
    tick(1);
    press_clear();
    chk("exec_clear_state", int'(state_code), 0);
    pulse_done(1'b0);
    chk("late_done_state", int'(state_code), 0);
    chk("late_done_valid", int'(result_valid), 0);

    // Asynchronous reset mid-EXEC
    press_enter(C_P_NONE);
    to_exec();
    tick(2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_state", int'(state_code), 0);
    chk("async_rst_outs", int'({load_a, load_b, load_op, alu_start, result_valid, err, busy}), 0);
    tick(2);
    reset = 1'b0;
    tick(2);
    press_enter(C_P_NONE);
    chk("restart_get_a", int'(state_code), 1);
    press_enter(C_P_A);
    chk("restart_get_b", int'(state_code), 2);

    tick(3);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Top-level control FSM for the FPGA calculator. It converts the user's ENTER/CLEAR button presses into one-cycle load enables for the operand A, operand B and operator capture registers. It then starts the ALU, waits for completion with a timeout, and holds the result or error for display. It sits between the synchronised button inputs and the en pins of the operand/operator registers and the ALU.

Parameters:
TIMEOUT_CYCLES, 64, max cycles to wait for alu_done after alu_start before declaring a timeout error
TW, 7, width of the timeout counter; must satisfy 2^TW > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_enter  input  1  synchronised, debounced ENTER level; a rising edge advances the sequence
btn_clear  input  1  synchronised, debounced CLEAR level; a rising edge aborts to IDLE
alu_done  input  1  ALU completion pulse
alu_error  input  1  ALU error flag (e.g. divide by zero), sampled only when alu_done=1
load_a  output  1  one-cycle enable to the operand A register
load_b  output  1  one-cycle enable to the operand B register
load_op  output  1  one-cycle enable to the operator register
alu_start  output  1  one-cycle ALU start pulse
result_valid  output  1  high while a valid result is displayed
err  output  1  high while an error (ALU or timeout) is displayed
busy  output  1  high in EXEC
state_code  output  3  encoded current state, for LED debug

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE, all outputs 0, timeout counter 0, edge-detector history regs 0.
  - state_code=0.
- Edge detection:
  - enter_rise = btn_enter & ~btn_enter_q; clear_rise likewise.
  - The _q history regs update every cycle.
  - A button held high produces exactly one event.
- States and state_code: IDLE=0, GET_A=1, GET_B=2, GET_OP=3, EXEC=4, SHOW=5, ERROR=6.
- Transitions (registered; at most one event acted on per cycle):
  - IDLE --enter_rise--> GET_A.
  - GET_A --enter_rise--> GET_B; load_a=1 in the same cycle as the accepted edge.
  - GET_B --enter_rise--> GET_OP; load_b=1 in that cycle.
  - GET_OP --enter_rise--> EXEC; load_op=1 in that cycle.
  - EXEC:
    - alu_start=1 in the first EXEC cycle only; counter cleared on entry, then increments each cycle.
    - alu_done=1 and alu_error=0 -> SHOW.
    - alu_done=1 and alu_error=1 -> ERROR.
    - counter reaches TIMEOUT_CYCLES-1 with no done -> ERROR.
  - SHOW / ERROR --enter_rise--> GET_A: starts a new calculation; no load pulse.
- Output timing:
  - load_a, load_b, load_op and alu_start are combinational decodes of the current state plus enter_rise (or the first-cycle flag).
  - They are asserted in the same cycle as the accepted event, so the data register captures the switches present at the press.
  - result_valid=1 only in SHOW; err=1 only in ERROR; busy=1 only in EXEC.
- Priority and boundary cases:
  - clear_rise has priority over everything.
    - From any state, go to IDLE next cycle.
    - Suppress any load or start pulse in that cycle.
  - CLEAR during EXEC abandons the operation; a late alu_done is ignored in IDLE.
  - alu_done arriving in the same cycle as alu_start is accepted.
  - alu_done outside EXEC is ignored.
  - enter_rise during EXEC is ignored and not queued.
  - Simultaneous enter_rise and clear_rise: clear wins.
  - Reset mid-EXEC: immediate IDLE; alu_start is never re-issued.

Decomposition:
- Package calc_pkg holds:
  - typedef enum logic [2:0] calc_state_t {IDLE, GET_A, GET_B, GET_OP, EXEC, SHOW, ERROR} with the codes above.
  - The localparam for the default TIMEOUT_CYCLES.
- One natural sub-module: rise_detect (1-bit registered edge detector, async reset), instantiated for enter and for clear.

Test Plan:
- Reset, then enter edges at cycles 5, 10, 15, 20 -> state_code 1, 2, 3, 4 in turn; load_a@10, load_b@15, load_op@20; alu_start@21 for exactly one cycle.
- In EXEC, alu_done=1 with alu_error=0 three cycles after start -> SHOW, result_valid=1, busy=0; another enter edge -> GET_A with no load pulse.
- In EXEC, alu_done=1 with alu_error=1 -> ERROR, err=1. Separate run with no alu_done for 64 cycles -> ERROR exactly 64 cycles after alu_start.
- Hold btn_enter high for 20 cycles in GET_A -> only one load_a pulse; state advances to GET_B only.
- Clear edge in GET_B coincident with an enter edge -> IDLE next cycle, load_b stays 0. Clear during EXEC followed by a late alu_done -> remains IDLE, result_valid=0.
- Assert reset asynchronously mid-EXEC (between clock edges) -> outputs 0 and state_code=0 before the next clk edge; after deassert, the enter sequence restarts normally.
